// File: rtl/led_chain_sched.sv
// Two-requester round-robin scheduler driving the serial LED chain: clear, 16 bits MSB-first, enable; optional idle replay.
// Latency: grant edge k -> done pulse at cycle k+33*DIV+1; requests are held off (no grant) while a frame is in flight.
module led_chain_sched #(
    parameter int DIV     = 4,
    parameter int REFRESH = 1048576
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_a,
    input  logic [15:0] data_a,
    input  logic        req_b,
    input  logic [15:0] data_b,
    input  logic        auto_en,
    output logic        grant_a,
    output logic        grant_b,
    output logic        busy,
    output logic        done,
    output logic        LED_CLK,
    output logic        LED_CLR,
    output logic        LED_DO,
    output logic        LED_EN
);

    localparam int CW = (DIV > 1) ? $clog2(2 * DIV) : 1;
    localparam int RW = $clog2(REFRESH);

    localparam logic [CW-1:0] CLR_LAST   = CW'(DIV - 1);
    localparam logic [CW-1:0] SHIFT_LAST = CW'(2 * DIV - 1);
    localparam logic [CW-1:0] HALF       = CW'(DIV);
    localparam logic [RW-1:0] REF_LAST   = RW'(REFRESH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLR,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_idx;
    logic [15:0]   r_frame;
    logic          r_ptr_b;
    logic [RW-1:0] r_ref;

    logic r_grant_a;
    logic r_grant_b;
    logic r_busy;
    logic r_done;
    logic r_led_clk;
    logic r_led_clr;
    logic r_led_do;
    logic r_led_en;

    state_t        w_state_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic [3:0]    w_idx_nxt;
    logic [15:0]   w_frame_nxt;
    logic          w_ptr_nxt;
    logic [RW-1:0] w_ref_nxt;
    logic          w_pick_b;
    logic          w_gnt_a;
    logic          w_gnt_b;
    logic          w_clk_nxt;
    logic          w_do_nxt;
    logic          w_clr_nxt;
    logic          w_en_nxt;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_frame_nxt = r_frame;
        w_ptr_nxt   = r_ptr_b;
        w_ref_nxt   = auto_en ? r_ref : '0;
        w_gnt_a     = 1'b0;
        w_gnt_b     = 1'b0;
        // B wins only when it is alone or the pointer favours it.
        w_pick_b    = req_b && (!req_a || r_ptr_b);

        case (r_state)
            S_IDLE: begin
                if (req_a || req_b) begin
                    w_gnt_a     = !w_pick_b;
                    w_gnt_b     = w_pick_b;
                    w_frame_nxt = w_pick_b ? data_b : data_a;
                    w_ptr_nxt   = !w_pick_b;
                    w_state_nxt = S_CLR;
                    w_cnt_nxt   = '0;
                    w_ref_nxt   = '0;
                end else if (auto_en && (r_ref == REF_LAST)) begin
                    w_state_nxt = S_CLR;
                    w_cnt_nxt   = '0;
                    w_ref_nxt   = '0;
                end else if (auto_en) begin
                    w_ref_nxt = r_ref + 1'b1;
                end
            end
            S_CLR: begin
                if (r_cnt == CLR_LAST) begin
                    w_state_nxt = S_SHIFT;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = 4'd15;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_SHIFT: begin
                if (r_cnt == SHIFT_LAST) begin
                    w_cnt_nxt = '0;
                    if (r_idx == 4'd0) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_idx_nxt = r_idx - 4'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Pin values are derived from the next state so they register alongside it.
        w_clk_nxt = (w_state_nxt == S_SHIFT) && (w_cnt_nxt >= HALF);
        w_do_nxt  = (w_state_nxt == S_SHIFT) && w_frame_nxt[w_idx_nxt];
        w_clr_nxt = (w_state_nxt != S_CLR);
        w_en_nxt  = r_led_en;
        if (w_state_nxt == S_DONE) begin
            w_en_nxt = 1'b1;
        end else if (w_state_nxt == S_CLR) begin
            w_en_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_idx     <= 4'd0;
            r_frame   <= 16'h0000;
            r_ptr_b   <= 1'b0;
            r_ref     <= '0;
            r_grant_a <= 1'b0;
            r_grant_b <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_led_clk <= 1'b0;
            r_led_clr <= 1'b1;
            r_led_do  <= 1'b0;
            r_led_en  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_idx     <= w_idx_nxt;
            r_frame   <= w_frame_nxt;
            r_ptr_b   <= w_ptr_nxt;
            r_ref     <= w_ref_nxt;
            r_grant_a <= w_gnt_a;
            r_grant_b <= w_gnt_b;
            r_busy    <= (w_state_nxt != S_IDLE);
            r_done    <= (w_state_nxt == S_DONE);
            r_led_clk <= w_clk_nxt;
            r_led_clr <= w_clr_nxt;
            r_led_do  <= w_do_nxt;
            r_led_en  <= w_en_nxt;
        end
    end

    assign grant_a = r_grant_a;
    assign grant_b = r_grant_b;
    assign busy    = r_busy;
    assign done    = r_done;
    assign LED_CLK = r_led_clk;
    assign LED_CLR = r_led_clr;
    assign LED_DO  = r_led_do;
    assign LED_EN  = r_led_en;

endmodule

// File: tb/tb_led_chain_sched.sv
// Randomised bench for led_chain_sched with a timeline-based reference model of the LED chain waveform.
module tb_led_chain_sched;

    localparam int DIV       = 4;
    localparam int REFRESH   = 16;
    localparam int FRAME_END = 33 * DIV + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_a = 1'b0;
    logic        req_b = 1'b0;
    logic        auto_en = 1'b0;
    logic [15:0] data_a = 16'h0000;
    logic [15:0] data_b = 16'h0000;
    logic        grant_a, grant_b, busy, done;
    logic        LED_CLK, LED_CLR, LED_DO, LED_EN;

    led_chain_sched #(.DIV(DIV), .REFRESH(REFRESH)) dut (
        .clk     (clk),
        .rst     (rst),
        .req_a   (req_a),
        .data_a  (data_a),
        .req_b   (req_b),
        .data_b  (data_b),
        .auto_en (auto_en),
        .grant_a (grant_a),
        .grant_b (grant_b),
        .busy    (busy),
        .done    (done),
        .LED_CLK (LED_CLK),
        .LED_CLR (LED_CLR),
        .LED_DO  (LED_DO),
        .LED_EN  (LED_EN)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;
    int cyc      = 0;

    // Reference model: a frame is a start edge plus a word; pins follow from elapsed cycles.
    bit          m_active = 1'b0;
    int          m_k      = 0;
    logic [15:0] m_frame  = 16'h0000;
    bit          m_ptr_b  = 1'b0;
    int          m_ref    = 0;
    int          m_gnt    = 0;
    logic [15:0] cap      = 16'h0000;
    logic        prev_clk = 1'b0;
    int          gnt_log[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_start(input int gnt, input logic [15:0] word);
        m_active = 1'b1;
        m_k      = cyc;
        m_gnt    = gnt;
        m_frame  = word;
        m_ref    = 0;
    endtask

    task automatic model_edge();
        bit idle;
        bit pick_b;
        idle = !m_active || ((cyc - m_k) > FRAME_END);
        if (idle) begin
            if (req_a || req_b) begin
                if (req_a && req_b) pick_b = m_ptr_b;
                else                pick_b = req_b;
                m_ptr_b = !pick_b;
                if (pick_b) model_start(2, data_b);
                else        model_start(1, data_a);
            end else if (auto_en && m_ref == REFRESH - 1) begin
                model_start(0, m_frame);
            end else if (auto_en) begin
                m_ref++;
            end else begin
                m_ref = 0;
            end
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_ptr_b  = 1'b0;
        m_ref    = 0;
        m_frame  = 16'h0000;
        m_gnt    = 0;
    endtask

    task automatic check_outputs();
        int d, j, ph;
        logic e_ga, e_gb, e_busy, e_done, e_clk, e_clr, e_do, e_en;
        e_ga = 0; e_gb = 0; e_busy = 0; e_done = 0;
        e_clk = 0; e_clr = 1; e_do = 0; e_en = 0;
        d = cyc - m_k;
        if (m_active) begin
            if (d == 1) begin
                e_ga = (m_gnt == 1);
                e_gb = (m_gnt == 2);
                cap  = 16'h0000;
            end
            if (d <= DIV) begin
                e_clr  = 0;
                e_busy = 1;
            end else if (d <= 33 * DIV) begin
                j      = (d - DIV - 1) / (2 * DIV);
                ph     = (d - DIV - 1) % (2 * DIV);
                e_do   = m_frame[15 - j];
                e_clk  = (ph >= DIV);
                e_busy = 1;
            end else if (d == FRAME_END) begin
                e_done = 1;
                e_en   = 1;
                e_busy = 1;
            end else begin
                e_en = 1;
            end
        end
        check("grant_a", grant_a, e_ga);
        check("grant_b", grant_b, e_gb);
        check("busy", busy, e_busy);
        check("done", done, e_done);
        check("LED_CLK", LED_CLK, e_clk);
        check("LED_CLR", LED_CLR, e_clr);
        check("LED_DO", LED_DO, e_do);
        check("LED_EN", LED_EN, e_en);
        if (LED_CLK && !prev_clk) cap = {cap[14:0], LED_DO};
        prev_clk = LED_CLK;
        if (m_active && d == FRAME_END) check("frame_bits", cap, m_frame);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_edge();
        cyc++;
        @(negedge clk);
        check_outputs();
        if (grant_a) gnt_log.push_back(1);
        if (grant_b) gnt_log.push_back(2);
        if (grant_a) req_a = 1'b0;
        if (grant_b) req_b = 1'b0;
    endtask

    task automatic do_reset(input logic hold_a, input logic hold_b);
        rst = 1'b0;
        #1;
        check("rst_LED_CLK", LED_CLK, 1'b0);
        check("rst_LED_CLR", LED_CLR, 1'b1);
        check("rst_LED_EN", LED_EN, 1'b0);
        check("rst_busy", busy, 1'b0);
        model_reset();
        tick();
        tick();
        req_a = hold_a;
        req_b = hold_b;
        rst = 1'b1;
    endtask

    initial begin
        model_reset();
        // Power-on reset, then a single directed frame from A.
        tick();
        tick();
        rst = 1'b1;
        tick();
        data_a = 16'hA5C3;
        req_a  = 1'b1;
        repeat (150) tick();

        // Both requesters held from reset: grants must alternate starting with A.
        do_reset(1'b1, 1'b1);
        data_a = 16'($urandom);
        data_b = 16'($urandom);
        gnt_log.delete();
        for (int t = 0; t < 1000 && gnt_log.size() < 4; t++) begin
            tick();
            if (!req_a) begin req_a = 1'b1; data_a = 16'($urandom); end
            if (!req_b) begin req_b = 1'b1; data_b = 16'($urandom); end
        end
        check("rr_count", 32'(gnt_log.size() >= 4), 32'd1);
        for (int i = 0; i < 4 && i < gnt_log.size(); i++)
            check("rr_order", 32'(gnt_log[i]), (i % 2 == 1) ? 32'd2 : 32'd1);
        repeat (300) tick();

        // B raised while A's frame is shifting.
        data_a = 16'($urandom);
        req_a  = 1'b1;
        repeat (60) tick();
        data_b = 16'($urandom);
        req_b  = 1'b1;
        repeat (250) tick();

        // Replay of 00FF with auto_en, then toggle auto_en to clear the counter.
        data_a  = 16'h00FF;
        req_a   = 1'b1;
        auto_en = 1'b1;
        repeat (400) tick();
        auto_en = 1'b0;
        repeat (10) tick();
        auto_en = 1'b1;
        repeat (12) tick();
        auto_en = 1'b0;
        repeat (5) tick();
        auto_en = 1'b1;
        repeat (200) tick();
        auto_en = 1'b0;
        repeat (20) tick();

        // Reset during bit 7, then both held: A must win.
        data_a = 16'($urandom);
        req_a  = 1'b1;
        for (int t = 0; t < 300; t++) begin
            tick();
            if (m_active && (cyc - m_k) == DIV + 1 + 2 * DIV * 8 + 2) break;
        end
        check("bit7_reached", 32'(m_active && (cyc - m_k) == DIV + 1 + 2 * DIV * 8 + 2), 32'd1);
        data_b = 16'($urandom);
        do_reset(1'b1, 1'b1);
        gnt_log.delete();
        repeat (300) tick();
        check("post_rst_first", (gnt_log.size() > 0) ? 32'(gnt_log[0]) : 32'd0, 32'd1);

        // Randomised traffic with withdrawals and auto_en changes.
        for (int t = 0; t < 3000; t++) begin
            tick();
            if (!req_a && $urandom_range(39) == 0) begin req_a = 1'b1; data_a = 16'($urandom); end
            else if (req_a && $urandom_range(299) == 0) req_a = 1'b0;
            if (!req_b && $urandom_range(39) == 0) begin req_b = 1'b1; data_b = 16'($urandom); end
            else if (req_b && $urandom_range(299) == 0) req_b = 1'b0;
            if ($urandom_range(499) == 0) auto_en = ~auto_en;
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/led_chain_sched.md
# led_chain_sched

Scheduler and serializer for the on-board serial LED shift chain (LED_CLK/LED_CLR/LED_DO/LED_EN). It arbitrates between two 16-bit frame requesters, for example the button-driven number path and a switch-loaded value, and sequences the chain: clear, 16 shifted bits MSB-first, then enable. When idle with auto_en set, it periodically replays the last frame. It sits between the top-level value sources and the LED pins, in the role of a plain LED driver.

## Interface
- DIV, 4: LED_CLK half-period in clk cycles; legal range 1..255.
- REFRESH, 1048576: idle clk cycles before an automatic replay; legal range ≥2.
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- req_a  in  1  requester A level request; held until grant_a.
- data_a  in  16  frame from A; sampled on the grant edge.
- req_b  in  1  requester B level request; held until grant_b.
- data_b  in  16  frame from B; sampled on the grant edge.
- auto_en  in  1  enables periodic replay of the last frame.
- grant_a  out  1  one-cycle pulse: A's frame accepted.
- grant_b  out  1  one-cycle pulse: B's frame accepted.
- busy  out  1  high from CLR through DONE.
- done  out  1  one-cycle pulse when a frame (request or replay) completes.
- LED_CLK  out  1  chain shift clock; the chain samples LED_DO on its rising edge.
- LED_CLR  out  1  chain clear, active-low.
- LED_DO  out  1  chain serial data.
- LED_EN  out  1  chain output enable, active-high.

## Operation
- Reset values:
  - grant_a, grant_b, busy, done, LED_CLK, LED_DO, LED_EN = 0.
  - LED_CLR = 1.
  - Frame register = 16'h0000.
  - Round-robin pointer = A.
  - Refresh counter = 0.
  - State = IDLE.
- **IDLE**, evaluated each cycle:
  - Request present → grant it, capture its data into the frame register, go to CLR.
  - Both requests present → grant the pointer's side; the pointer then flips to the other side. After any grant, the pointer points away from the granted side.
  - No request, auto_en=1 and refresh counter = REFRESH-1 → go to CLR with the frame register unchanged; no grant.
  - Refresh counter increments only in IDLE with auto_en=1. It clears on auto_en=0 and on entry to CLR.
- **CLR**: LED_CLR=0 and LED_EN=0 for DIV cycles, then go to SHIFT with bit index 15.
- **SHIFT**, per bit:
  - LED_DO = frame[idx] for 2·DIV cycles.
  - LED_CLK=0 for the first DIV cycles and 1 for the last DIV cycles.
  - Idx decrements after the high half. After idx 0 → DONE.
  - LED_EN=0 and LED_CLR=1 throughout.
- **DONE**, one cycle:
  - done=1, LED_CLK=0, LED_DO=0, LED_EN=1.
  - Next state IDLE.
  - LED_EN stays 1 until the next CLR.
- Requests arriving while busy are not granted; they are serviced from IDLE after DONE.
- A request withdrawn before its grant is dropped with no side effect.
- A grant pulse is never issued outside IDLE→CLR.
- All pin outputs are registered; there are no combinational paths from inputs to pins.

## Timing
- Grant/capture edge k: grant_x=1 and busy=1 during cycle k+1.
- LED_CLR=0 during cycles k+1..k+DIV.
- Bit 15 is on LED_DO from cycle k+DIV+1. First LED_CLK rise at cycle k+2·DIV+1.
- Bit n (n=15..0, j=15-n) occupies cycles k+DIV+1+2·DIV·j .. k+DIV+2·DIV·(j+1).
- done=1 at cycle k+33·DIV+1. busy drops after that cycle.
- Earliest next grant edge is k+33·DIV+2, which gives a minimum of one IDLE cycle between frames.
- DIV=4: done at k+133.
- Replay timing is identical, with the start edge being the one where the counter hits REFRESH-1.
- Reset asserted mid-frame forces all reset values immediately. No partial frame resumes; pending requests are re-arbitrated after release.

## Test plan
- Reset, then req_a=1 with data_a=16'hA5C3, DIV=4:
  - grant_a pulses 1 cycle and LED_CLR low 4 cycles.
  - 16 LED_CLK rising edges sample 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1.
  - done at 133 cycles after the grant edge; LED_EN=1 afterwards.
- req_a and req_b both high from reset:
  - grant order is A, B, A, B, … over four frames.
  - Each data word is captured at its own grant; the pointer alternates.
- req_b raised mid-frame (during SHIFT of A's frame):
  - no grant_b until after done.
  - grant_b one IDLE cycle after done; busy low exactly one cycle between frames.
- auto_en=1, REFRESH=16, no requests, after a frame of 16'h00FF:
  - replay starts after 16 IDLE cycles with no grant pulse.
  - LED_DO shifts 16'h00FF again and done pulses.
  - Clearing auto_en resets the counter.
- rst pulled low at bit 7 of a frame:
  - LED_CLK=0, LED_CLR=1, LED_EN=0, busy=0 immediately.
  - Frame register = 0; after release, a held req_b is granted first only if the pointer favors it (pointer = A, so A wins if both are held).
